demux5b16_reg: RTL and testbench
================================

// Module: demux5b16_reg
// PURPOSE
//   Registered 1-to-5 demultiplexer for 16-bit datapath values. It is the write-side counterpart of mux5b16.
//   A 16-bit word on I is steered into one of five holding registers (A..E) chosen by S. Each accepted write
//   raises a one-cycle valid strobe for the chosen output. Writes with an out-of-range select are rejected,
//   flagged and counted. Used as a write-back router that feeds the five mux5b16 inputs.
// PARAMETERS
//   WIDTH   16   data width of I and of outputs A..E
//   CNTW    4    width of the rejected-write counter ERRCNT
// PORTS
//   CLK     in   1      system clock; all state changes on the rising edge
//   Reset   in   1      asynchronous, active-high reset
//   CLR     in   1      synchronous clear of A..E, the strobes, ERR and ERRCNT
//   WE      in   1      write request, sampled on the rising CLK edge
//   S       in   3      destination select: 0=A 1=B 2=C 3=D 4=E, 5..7 invalid
//   I       in   WIDTH  write data
//   A..E    out  WIDTH  holding registers, one per destination (five ports)
//   VA..VE  out  1      write strobes, one per destination; each high for one cycle after that register updates
//   ERR     out  1      sticky flag, set by a write with an invalid select
//   ERRCNT  out  CNTW   saturating count of rejected writes
// BEHAVIOUR
//   - Reset=1 (asynchronous, takes effect immediately, including mid-write):
//     A..E=0, VA..VE=0, ERR=0, ERRCNT=0. State is held at these values while Reset is high.
//   - Per rising edge, priority order is Reset > CLR > WE.
//   - CLR=1: apply the same values as Reset on this edge. Any WE on the same edge is dropped and not counted.
//   - WE=1, S in 0..4:
//     * the selected register takes I on this edge; latency is 1 cycle (new value visible after the edge);
//     * the matching strobe is 1 for exactly the following cycle;
//     * the other four registers hold their values and their strobes are 0.
//   - WE=1, S in 5..7:
//     * no register changes and all strobes are 0;
//     * ERR is set to 1;
//     * ERRCNT increments, saturating at 2^CNTW-1 (it does not wrap).
//   - WE=0: all registers hold and all strobes are 0. ERR and ERRCNT hold.
//   - Back-to-back writes are accepted every cycle with no stall:
//     * writes to the same destination on consecutive cycles keep that strobe high for both cycles
//       and the register shows each value in turn;
//     * writes to different destinations give one strobe per cycle, each for its own destination.
//   - At most one strobe is high in any cycle (one-hot or all zero).
//   - Strobes are registered outputs, not combinational decodes of WE/S.
//   - S and I are ignored when WE=0. X on S while WE=0 must not disturb any state.
//   - Only the lowest WIDTH bits of I are stored. There is no arithmetic on the data path.
//   - ERR clears only on Reset or CLR.
// TESTING
//   1. Reset high, then release; WE=0 -> A..E=0, all strobes 0, ERR=0, ERRCNT=0.
//   2. Writes I=5,10,15,20,25 with S=0..4 on consecutive cycles -> A=5 B=10 C=15 D=20 E=25;
//      VA..VE each pulse once, in that order.
//   3. WE=1, S=3, I=16'hBEEF -> D=BEEF and VD=1 for one cycle; A,B,C,E unchanged.
//   4. WE=1 with S=5, 6 and 7, then 20 more invalid writes -> A..E unchanged, ERR=1, ERRCNT saturates at 15.
//   5. CLR=1 together with WE=1, S=1, I=7 -> all registers 0, B stays 0, VB=0, ERR=0, ERRCNT=0.
//   6. Reset asserted mid-cycle during a WE burst -> outputs go to 0 immediately, before the next CLK edge.

Source files
------------

// File: rtl/demux5b16_reg.sv
// demux5b16_reg -- registered 1-to-5 demultiplexer for datapath words.
//
// A write on I is steered into one of five holding registers (A..E) chosen
// by S. Each accepted write raises a one-cycle registered strobe (VA..VE)
// for its destination. Writes with an invalid select (5..7) leave the
// registers alone, set the sticky ERR flag and bump a saturating counter.
//
// Ports
//   CLK     in   1      system clock, rising edge
//   Reset   in   1      asynchronous active-high reset
//   CLR     in   1      synchronous clear of registers, strobes, ERR, ERRCNT
//   WE      in   1      write request
//   S       in   3      destination select: 0=A 1=B 2=C 3=D 4=E, 5..7 invalid
//   I       in   WIDTH  write data
//   A..E    out  WIDTH  holding registers
//   VA..VE  out  1      write strobes, high the cycle after their register updates
//   ERR     out  1      sticky invalid-select flag
//   ERRCNT  out  CNTW   saturating count of rejected writes
module demux5b16_reg #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             CLR,
  input  logic             WE,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic             VA,
  output logic             VB,
  output logic             VC,
  output logic             VD,
  output logic             VE,
  output logic             ERR,
  output logic [CNTW-1:0]  ERRCNT
);

  localparam int NDEST = 5;

  logic [WIDTH-1:0] hold_q [NDEST];
  logic [NDEST-1:0] strobe_q;
  logic [NDEST-1:0] sel;
  logic             bad_write;
  logic             err_q;
  logic [CNTW-1:0]  errcnt_q;
  logic             cnt_full;

  // Decode is gated by WE first so that an undefined S while idle can
  // never reach the write enables.
  always_comb begin
    sel       = '0;
    bad_write = 1'b0;
    if (WE) begin
      case (S)
        3'd0:    sel = 5'b00001;
        3'd1:    sel = 5'b00010;
        3'd2:    sel = 5'b00100;
        3'd3:    sel = 5'b01000;
        3'd4:    sel = 5'b10000;
        default: bad_write = 1'b1;
      endcase
    end
  end

  assign cnt_full = &errcnt_q;

  for (genvar g = 0; g < NDEST; g++) begin : g_hold
    always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
        hold_q[g] <= '0;
      end else if (CLR) begin
        hold_q[g] <= '0;
      end else if (sel[g]) begin
        hold_q[g] <= I;
      end
    end
  end

  // Strobes are a registered copy of the decode, so they follow the data
  // by exactly one cycle and stay high across back-to-back same-target writes.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      strobe_q <= '0;
    end else if (CLR) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= sel;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else if (CLR) begin
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else if (bad_write) begin
      err_q <= 1'b1;
      if (!cnt_full) begin
        errcnt_q <= errcnt_q + 1'b1;
      end
    end
  end

  assign A      = hold_q[0];
  assign B      = hold_q[1];
  assign C      = hold_q[2];
  assign D      = hold_q[3];
  assign E      = hold_q[4];
  assign VA     = strobe_q[0];
  assign VB     = strobe_q[1];
  assign VC     = strobe_q[2];
  assign VD     = strobe_q[3];
  assign VE     = strobe_q[4];
  assign ERR    = err_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_demux5b16_reg.sv
// tb_demux5b16_reg -- self-checking bench for demux5b16_reg.
// A behavioural model (arrays + integer arithmetic) is compared against the
// DUT on every falling edge; directed literal checks pin the model.
module tb_demux5b16_reg;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        CLR = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  S = 3'd0;
  logic [15:0] I = 16'd0;
  logic [15:0] A, B, C, D, E;
  logic        VA, VB, VC, VD, VE;
  logic        ERR;
  logic [3:0]  ERRCNT;

  int npass = 0;
  int ntotal = 0;

  demux5b16_reg #(.WIDTH(16), .CNTW(4)) dut (
    .CLK(CLK), .Reset(Reset), .CLR(CLR), .WE(WE), .S(S), .I(I),
    .A(A), .B(B), .C(C), .D(D), .E(E),
    .VA(VA), .VB(VB), .VC(VC), .VD(VD), .VE(VE),
    .ERR(ERR), .ERRCNT(ERRCNT)
  );

  always #5 CLK = ~CLK;

  // Behavioural model
  int m_reg [5];
  int m_v;
  int m_err;
  int m_cnt;

  task automatic model_clear();
    for (int k = 0; k < 5; k++) m_reg[k] = 0;
    m_v = 0;
    m_err = 0;
    m_cnt = 0;
  endtask

  initial model_clear();

  always @(posedge CLK or posedge Reset) begin
    if (Reset || CLR) begin
      model_clear();
    end else begin
      m_v = 0;
      if (WE) begin
        if (int'(S) < 5) begin
          m_reg[int'(S)] = int'(I);
          m_v = 1 << int'(S);
        end else begin
          m_err = 1;
          m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    ntotal++;
    if (got == want) npass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  function automatic int dut_v();
    return int'({VE, VD, VC, VB, VA});
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ":A"}, int'(A), m_reg[0]);
    chk({tag, ":B"}, int'(B), m_reg[1]);
    chk({tag, ":C"}, int'(C), m_reg[2]);
    chk({tag, ":D"}, int'(D), m_reg[3]);
    chk({tag, ":E"}, int'(E), m_reg[4]);
    chk({tag, ":V"}, dut_v(), m_v);
    chk({tag, ":ERR"}, int'(ERR), m_err);
    chk({tag, ":ERRCNT"}, int'(ERRCNT), m_cnt);
    ntotal++;
    if ($countones(dut_v()) <= 1) npass++;
    else $display("FAIL %s:onehot got=%0h want=onehot_or_zero", tag, dut_v());
  endtask

  always @(negedge CLK) compare_all("cyc");

  task automatic drive(input logic we, input logic [2:0] s, input logic [15:0] d, input logic clr);
    @(posedge CLK);
    #2;
    WE = we; S = s; I = d; CLR = clr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  initial begin
    // 1. reset
    #1 Reset = 1'b1;
    #12;
    chk("rst_A", int'(A), 0);
    chk("rst_V", dut_v(), 0);
    Reset = 1'b0;
    idle();
    idle();
    chk("post_rst_ERRCNT", int'(ERRCNT), 0);
    chk("post_rst_ERR", int'(ERR), 0);

    // 2. fill A..E on consecutive cycles; check strobe order
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'(k), 16'(5 * (k + 1)), 1'b0);
      if (k > 0) chk("order_V", dut_v(), 1 << (k - 1));
    end
    idle();
    chk("order_VE", dut_v(), 5'b10000);
    chk("fill_A", int'(A), 5);
    chk("fill_B", int'(B), 10);
    chk("fill_C", int'(C), 15);
    chk("fill_D", int'(D), 20);
    chk("fill_E", int'(E), 25);
    idle();
    chk("fill_V_gone", dut_v(), 0);

    // X-ish select while idle must not disturb anything
    drive(1'b0, 3'bxxx, 16'hFFFF, 1'b0);
    idle();

    // 3. single write to D
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0);
    idle();
    chk("beef_D", int'(D), 16'hBEEF);
    chk("beef_VD", dut_v(), 5'b01000);
    chk("beef_C", int'(C), 15);
    idle();
    chk("beef_VD_off", dut_v(), 0);

    // same-destination back-to-back: strobe stays high, values in turn
    drive(1'b1, 3'd1, 16'h1111, 1'b0);
    drive(1'b1, 3'd1, 16'h2222, 1'b0);
    chk("b2b_B1", int'(B), 16'h1111);
    chk("b2b_VB1", dut_v(), 5'b00010);
    idle();
    chk("b2b_B2", int'(B), 16'h2222);
    chk("b2b_VB2", dut_v(), 5'b00010);

    // 4. invalid selects: 5,6,7 then 20 more -> saturates at 15
    drive(1'b1, 3'd5, 16'h0AAA, 1'b0);
    idle();
    chk("inv_ERR", int'(ERR), 1);
    chk("inv_CNT1", int'(ERRCNT), 1);
    drive(1'b1, 3'd6, 16'h0BBB, 1'b0);
    drive(1'b1, 3'd7, 16'h0CCC, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, 3'(5 + (k % 3)), 16'(k), 1'b0);
    idle();
    idle();
    chk("sat_CNT", int'(ERRCNT), 15);
    chk("sat_ERR", int'(ERR), 1);
    chk("sat_D", int'(D), 16'hBEEF);
    chk("sat_V", dut_v(), 0);

    // 5. CLR together with a write to B
    drive(1'b1, 3'd1, 16'd7, 1'b1);
    idle();
    chk("clr_B", int'(B), 0);
    chk("clr_D", int'(D), 0);
    chk("clr_VB", dut_v(), 0);
    chk("clr_ERR", int'(ERR), 0);
    chk("clr_CNT", int'(ERRCNT), 0);

    // 6. async reset in the middle of a write burst
    drive(1'b1, 3'd0, 16'h1234, 1'b0);
    drive(1'b1, 3'd2, 16'h5678, 1'b0);
    drive(1'b1, 3'd4, 16'h9ABC, 1'b0);
    chk("pre_rst_A", int'(A), 16'h1234);
    chk("pre_rst_VC", dut_v(), 5'b00100);
    #1 Reset = 1'b1;
    #1;
    chk("async_A", int'(A), 0);
    chk("async_C", int'(C), 0);
    chk("async_V", dut_v(), 0);
    @(posedge CLK);
    #2;
    chk("hold_rst_E", int'(E), 0);
    Reset = 1'b0;
    WE = 1'b0;
    idle();
    drive(1'b1, 3'd4, 16'h0042, 1'b0);
    idle();
    chk("after_rst_E", int'(E), 16'h0042);
    idle();
    idle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
